// File: rtl/fp8_accumulator_if.sv
// rtl/fp8_accumulator_if.sv - term/result stream bundle for the FP8 accumulator
// master drives terms and accepts results; slave is the accumulator.
interface fp8_accumulator_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_first;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] acc;
    logic       busy;

    modport master (
        output in_valid,
        output in_data,
        output in_first,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  acc,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_first,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output acc,
        output busy
    );
endinterface

// File: rtl/fp8_accumulator.sv
// rtl/fp8_accumulator.sv - FP8 E4M3 sequential adder-accumulator
// Each term runs IDLE -> ALIGN -> ADD -> NORM (1..7 cycles) -> IDLE or OUT.
module fp8_accumulator #(
    parameter int GUARD_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    fp8_accumulator_if.slave bus
);
    // significand width: hidden bit + 3 mantissa bits + guard bits
    localparam int SW = 4 + GUARD_BITS;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        OUT
    } state_t;

    state_t            state;
    logic [7:0]        op_a;
    logic [7:0]        op_b;
    logic              last_r;
    logic [7:0]        acc_r;
    logic [7:0]        out_data_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic [SW-1:0]     big_sig;
    logic [SW-1:0]     small_sig;
    logic              big_sign;
    logic              do_sub;
    logic              res_zero;
    logic [SW:0]       sum;
    logic signed [5:0] exp_r;

    logic [3:0]        exp_a;
    logic [3:0]        exp_b;
    logic [3:0]        exp_diff;
    logic [SW-1:0]     sig_a;
    logic [SW-1:0]     sig_b;
    logic [SW-1:0]     small_shifted;
    logic              a_big;

    // Operand ordering and alignment; an exponent of 0 is a zero significand.
    always_comb begin
        exp_a = op_a[6:3];
        exp_b = op_b[6:3];
        sig_a = (exp_a == 4'd0) ? '0 : {1'b1, op_a[2:0], {GUARD_BITS{1'b0}}};
        sig_b = (exp_b == 4'd0) ? '0 : {1'b1, op_b[2:0], {GUARD_BITS{1'b0}}};
        a_big = (exp_a > exp_b) || ((exp_a == exp_b) && (sig_a >= sig_b));
        exp_diff = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
        if (int'(exp_diff) >= SW) begin
            small_shifted = '0;
        end else begin
            small_shifted = (a_big ? sig_b : sig_a) >> exp_diff;
        end
    end

    logic [SW:0] add_res;

    always_comb begin
        if (do_sub) begin
            add_res = {1'b0, big_sig} - {1'b0, small_sig};
        end else begin
            add_res = {1'b0, big_sig} + {1'b0, small_sig};
        end
    end

    logic signed [5:0] norm_exp;
    logic [2:0]        norm_man;
    logic              norm_done;
    logic [7:0]        commit_val;

    // Final NORM cycle: either a carry (one right shift folded into commit)
    // or the hidden bit already in place; guard bits are simply dropped.
    always_comb begin
        norm_exp  = sum[SW] ? (exp_r + 6'sd1) : exp_r;
        norm_man  = sum[SW] ? sum[SW-1 -: 3] : sum[SW-2 -: 3];
        norm_done = res_zero || sum[SW] || sum[SW-1];
        if (res_zero || (norm_exp < 6'sd1)) begin
            commit_val = 8'h00;
        end else if (norm_exp > 6'sd15) begin
            commit_val = {big_sign, 7'h7F};
        end else begin
            commit_val = {big_sign, norm_exp[3:0], norm_man};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_a        <= 8'h00;
            op_b        <= 8'h00;
            last_r      <= 1'b0;
            acc_r       <= 8'h00;
            out_data_r  <= 8'h00;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            big_sig     <= '0;
            small_sig   <= '0;
            big_sign    <= 1'b0;
            do_sub      <= 1'b0;
            res_zero    <= 1'b0;
            sum         <= '0;
            exp_r       <= 6'sd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        op_a       <= bus.in_first ? 8'h00 : acc_r;
                        op_b       <= bus.in_data;
                        last_r     <= bus.in_last;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= ALIGN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ALIGN: begin
                    big_sig   <= a_big ? sig_a : sig_b;
                    small_sig <= small_shifted;
                    exp_r     <= $signed({2'b00, (a_big ? exp_a : exp_b)});
                    big_sign  <= a_big ? op_a[7] : op_b[7];
                    do_sub    <= op_a[7] ^ op_b[7];
                    state     <= ADD;
                end
                ADD: begin
                    sum      <= add_res;
                    res_zero <= (add_res == '0);
                    state    <= NORM;
                end
                NORM: begin
                    if (norm_done) begin
                        acc_r <= commit_val;
                        if (last_r) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= commit_val;
                            state       <= OUT;
                        end else begin
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        sum   <= sum << 1;
                        exp_r <= exp_r - 6'sd1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.acc       = acc_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_fp8_accumulator.sv
// tb/tb_fp8_accumulator.sv - self-checking bench for fp8_accumulator
module tb_fp8_accumulator;
    localparam int G  = 3;
    localparam int NV = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fp8_accumulator_if bus ();

    fp8_accumulator #(.GUARD_BITS(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic       single;
        logic [7:0] want;
        int         lat;
    } vec_t;

    vec_t vecs [NV];

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%02h want=%02h", name, got, want);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0b want=%0b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Exact-value reference: magnitudes as integers scaled by 2^-(10+G),
    // the smaller one floored to the larger operand's guard-bit grid.
    function automatic logic [7:0] model_add(input logic [7:0] a, input logic [7:0] b);
        longint ma, mb, mbig, msmall, r;
        int eb, p, er;
        logic sb;
        logic [2:0] man;
        ma = (a[6:3] == 4'd0) ? 64'd0 : (longint'(8 + a[2:0]) << (a[6:3] + G));
        mb = (b[6:3] == 4'd0) ? 64'd0 : (longint'(8 + b[2:0]) << (b[6:3] + G));
        if (ma >= mb) begin
            mbig = ma; msmall = mb; eb = int'(a[6:3]); sb = a[7];
        end else begin
            mbig = mb; msmall = ma; eb = int'(b[6:3]); sb = b[7];
        end
        msmall = (msmall >> eb) << eb;
        r = (a[7] == b[7]) ? (mbig + msmall) : (mbig - msmall);
        if (r == 0) return 8'h00;
        p = 0;
        for (int i = 0; i < 40; i++) if (r[i]) p = i;
        er = p - G - 3;
        if (er > 15) return {sb, 7'h7F};
        if (er < 1) return 8'h00;
        man = 3'((p >= 3) ? (r >> (p - 3)) : (r << (3 - p)));
        return {sb, 4'(er), man};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_term(input logic [7:0] d, input logic f, input logic l);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_first = f;
        bus.in_last  = l;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) check1("in_ready_wait", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check1("out_valid_wait", bus.out_valid, 1'b1);
    endtask

    task automatic take_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check1({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check8({tag, "_out_data"}, bus.out_data, 8'h00);
        check8({tag, "_acc"}, bus.acc, 8'h00);
        check1({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check1("in_ready_after_reset", bus.in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        logic [7:0] m, d;

        vecs[0] = '{8'h38, 8'h40, 1'b0, 8'h44, 4};
        vecs[1] = '{8'h38, 8'hB8, 1'b0, 8'h00, 0};
        vecs[2] = '{8'h38, 8'hB6, 1'b0, 8'h20, 7};
        vecs[3] = '{8'h7F, 8'h7F, 1'b0, 8'h7F, 4};
        vecs[4] = '{8'h78, 8'h38, 1'b0, 8'h78, 4};
        vecs[5] = '{8'h05, 8'h00, 1'b1, 8'h00, 0};
        vecs[6] = '{8'h38, 8'h38, 1'b0, 8'h40, 4};
        vecs[7] = '{8'hC0, 8'h38, 1'b0, 8'hB8, 5};
        vecs[8] = '{8'hFF, 8'hFF, 1'b0, 8'hFF, 4};

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].single) begin
                send_term(vecs[i].d0, 1'b1, 1'b1);
            end else begin
                send_term(vecs[i].d0, 1'b1, 1'b0);
                send_term(vecs[i].d1, 1'b0, 1'b1);
            end
            wait_out(lat);
            check8($sformatf("vec%0d_out", i), bus.out_data, vecs[i].want);
            if (vecs[i].lat != 0) check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            take_out();
            check8($sformatf("vec%0d_acc", i), bus.acc, vecs[i].want);
            check1($sformatf("vec%0d_idle", i), bus.busy, 1'b0);
        end

        // continue from the retained accumulator without in_first
        send_term(8'h38, 1'b1, 1'b0);
        send_term(8'h40, 1'b0, 1'b1);
        wait_out(lat);
        take_out();
        send_term(8'h38, 1'b0, 1'b1);
        wait_out(lat);
        check8("continue_out", bus.out_data, 8'h48);
        take_out();

        // output backpressure, then an immediate new term
        send_term(8'h38, 1'b1, 1'b0);
        send_term(8'h40, 1'b0, 1'b1);
        wait_out(lat);
        for (int c = 0; c < 5; c++) begin
            check1($sformatf("bp%0d_out_valid", c), bus.out_valid, 1'b1);
            check8($sformatf("bp%0d_out_data", c), bus.out_data, 8'h44);
            check1($sformatf("bp%0d_in_ready", c), bus.in_ready, 1'b0);
            @(posedge clk); #1;
        end
        take_out();
        check1("bp_in_ready_after", bus.in_ready, 1'b1);
        check1("bp_out_valid_after", bus.out_valid, 1'b0);
        send_term(8'h40, 1'b1, 1'b1);
        wait_out(lat);
        check8("bp_next_out", bus.out_data, 8'h40);
        check_int("bp_next_latency", lat, 4);
        take_out();

        // reset in the middle of NORM left-shifting
        send_term(8'h38, 1'b1, 1'b0);
        send_term(8'hB6, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check1("norm_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_norm");
        release_reset();
        send_term(8'h38, 1'b1, 1'b0);
        send_term(8'h40, 1'b0, 1'b1);
        wait_out(lat);
        check8("rst_norm_fresh", bus.out_data, 8'h44);
        take_out();

        // reset while a result is pending
        send_term(8'h38, 1'b1, 1'b0);
        send_term(8'h40, 1'b0, 1'b1);
        wait_out(lat);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_out");
        release_reset();
        send_term(8'h38, 1'b1, 1'b0);
        send_term(8'hB6, 1'b0, 1'b1);
        wait_out(lat);
        check8("rst_out_fresh", bus.out_data, 8'h20);
        take_out();

        // randomized sums against the reference model
        for (int s = 0; s < 150; s++) begin
            n = int'($urandom_range(1, 5));
            m = 8'h00;
            for (int t = 0; t < n; t++) begin
                d = 8'($urandom_range(0, 255));
                m = model_add((t == 0) ? 8'h00 : m, d);
                send_term(d, t == 0, t == n - 1);
            end
            wait_out(lat);
            check8($sformatf("rand%0d_out", s), bus.out_data, m);
            check8($sformatf("rand%0d_acc", s), bus.acc, m);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            check8($sformatf("rand%0d_hold", s), bus.out_data, m);
            take_out();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
